// File: rtl/decode_stage_hz.sv
// RV32I decode stage: register file, control/ALU decode, immediates, load-use hazard
// detection and the ID/EX pipeline register. Optional macro: DECODE_WB_BYPASS_EN.
module decode_stage_hz #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       InstrD,
  input  logic [XLEN-1:0]   PCD,
  input  logic [XLEN-1:0]   PCPlus4D,
  input  logic              ValidD,
  input  logic              FlushE,
  input  logic              RegWriteW,
  input  logic [ADDR_W-1:0] RDW,
  input  logic [XLEN-1:0]   ResultW,
  output logic              StallD,
  output logic              ValidE,
  output logic              RegWriteE,
  output logic              ALUSrcE,
  output logic              MemWriteE,
  output logic              ResultSrcE,
  output logic              BranchE,
  output logic [2:0]        ALUControlE,
  output logic [XLEN-1:0]   RD1_E,
  output logic [XLEN-1:0]   RD2_E,
  output logic [XLEN-1:0]   Imm_Ext_E,
  output logic [XLEN-1:0]   PCE,
  output logic [XLEN-1:0]   PCPlus4E,
  output logic [ADDR_W-1:0] RD_E,
  output logic [ADDR_W-1:0] RS1_E,
  output logic [ADDR_W-1:0] RS2_E
);

  localparam int unsigned NREG = 2 ** ADDR_W;

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpR     = 7'b0110011;
  localparam logic [6:0] OpIAlu  = 7'b0010011;
  localparam logic [6:0] OpBeq   = 7'b1100011;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluSlt = 3'b101;

  typedef enum logic [1:0] {ImmI, ImmS, ImmB} imm_src_e;

  // Instruction fields
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic              funct7_b5;
  logic [ADDR_W-1:0] rs1_d, rs2_d, rd_d;

  assign opcode    = InstrD[6:0];
  assign funct3    = InstrD[14:12];
  assign funct7_b5 = InstrD[30];
  assign rs1_d     = InstrD[15 +: ADDR_W];
  assign rs2_d     = InstrD[20 +: ADDR_W];
  assign rd_d      = InstrD[7 +: ADDR_W];

  // Register file
  logic [XLEN-1:0] rf_q [NREG];
  logic [XLEN-1:0] rd1_d, rd2_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
    end else if (RegWriteW && (RDW != '0)) begin
      rf_q[RDW] <= ResultW;
    end
  end

`ifdef DECODE_WB_BYPASS_EN
  // Write-through: a writeback to the register being read is visible in the same cycle.
  always_comb begin
    rd1_d = '0;
    rd2_d = '0;
    if (rs1_d != '0) begin
      rd1_d = (RegWriteW && (RDW == rs1_d)) ? ResultW : rf_q[rs1_d];
    end
    if (rs2_d != '0) begin
      rd2_d = (RegWriteW && (RDW == rs2_d)) ? ResultW : rf_q[rs2_d];
    end
  end
`else
  always_comb begin
    rd1_d = '0;
    rd2_d = '0;
    if (rs1_d != '0) begin
      rd1_d = rf_q[rs1_d];
    end
    if (rs2_d != '0) begin
      rd2_d = rf_q[rs2_d];
    end
  end
`endif

  // Main decode
  logic     reg_write_d, alu_src_d, mem_write_d, result_src_d, branch_d;
  imm_src_e imm_src;
  logic     is_r_type, is_alu_op;

  always_comb begin
    reg_write_d  = 1'b0;
    alu_src_d    = 1'b0;
    mem_write_d  = 1'b0;
    result_src_d = 1'b0;
    branch_d     = 1'b0;
    imm_src      = ImmI;
    is_r_type    = 1'b0;
    is_alu_op    = 1'b0;
    unique case (opcode)
      OpLoad: begin
        reg_write_d  = 1'b1;
        alu_src_d    = 1'b1;
        result_src_d = 1'b1;
        imm_src      = ImmI;
      end
      OpStore: begin
        mem_write_d = 1'b1;
        alu_src_d   = 1'b1;
        imm_src     = ImmS;
      end
      OpR: begin
        reg_write_d = 1'b1;
        is_r_type   = 1'b1;
        is_alu_op   = 1'b1;
      end
      OpIAlu: begin
        reg_write_d = 1'b1;
        alu_src_d   = 1'b1;
        imm_src     = ImmI;
        is_alu_op   = 1'b1;
      end
      OpBeq: begin
        branch_d = 1'b1;
        imm_src  = ImmB;
      end
      default: ;
    endcase
  end

  // ALU decode
  logic [2:0] alu_ctrl_d;

  always_comb begin
    alu_ctrl_d = AluAdd;
    if (opcode == OpBeq) begin
      alu_ctrl_d = AluSub;
    end else if (is_alu_op) begin
      unique case (funct3)
        3'b000:  alu_ctrl_d = (is_r_type && funct7_b5) ? AluSub : AluAdd;
        3'b010:  alu_ctrl_d = AluSlt;
        3'b110:  alu_ctrl_d = AluOr;
        3'b111:  alu_ctrl_d = AluAnd;
        default: alu_ctrl_d = AluAdd;
      endcase
    end
  end

  // Immediate generation
  logic [XLEN-1:0] imm_d;

  always_comb begin
    imm_d = '0;
    unique case (imm_src)
      ImmI: imm_d = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
      ImmS: imm_d = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      ImmB: imm_d = {{(XLEN-13){InstrD[31]}}, InstrD[31], InstrD[7], InstrD[30:25],
                     InstrD[11:8], 1'b0};
      default: imm_d = '0;
    endcase
  end

  // ID/EX register
  logic              valid_e_q, reg_write_e_q, alu_src_e_q, mem_write_e_q;
  logic              result_src_e_q, branch_e_q;
  logic [2:0]        alu_ctrl_e_q;
  logic [XLEN-1:0]   rd1_e_q, rd2_e_q, imm_e_q, pc_e_q, pc_plus4_e_q;
  logic [ADDR_W-1:0] rd_e_q, rs1_e_q, rs2_e_q;

  // Load-use: rs2 is compared even for I-type, which may stall needlessly but never wrongly.
  assign StallD = valid_e_q & result_src_e_q & (rd_e_q != '0) &
                  ((rd_e_q == rs1_d) | (rd_e_q == rs2_d));

  logic bubble;
  logic ctrl_en;

  assign bubble  = FlushE | StallD;
  assign ctrl_en = ~bubble & ValidD;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_e_q      <= 1'b0;
      reg_write_e_q  <= 1'b0;
      alu_src_e_q    <= 1'b0;
      mem_write_e_q  <= 1'b0;
      result_src_e_q <= 1'b0;
      branch_e_q     <= 1'b0;
      alu_ctrl_e_q   <= 3'b000;
      rd1_e_q        <= '0;
      rd2_e_q        <= '0;
      imm_e_q        <= '0;
      pc_e_q         <= '0;
      pc_plus4_e_q   <= '0;
      rd_e_q         <= '0;
      rs1_e_q        <= '0;
      rs2_e_q        <= '0;
    end else begin
      valid_e_q      <= ctrl_en;
      reg_write_e_q  <= ctrl_en & reg_write_d;
      alu_src_e_q    <= ctrl_en & alu_src_d;
      mem_write_e_q  <= ctrl_en & mem_write_d;
      result_src_e_q <= ctrl_en & result_src_d;
      branch_e_q     <= ctrl_en & branch_d;
      alu_ctrl_e_q   <= ctrl_en ? alu_ctrl_d : 3'b000;
      // Data and address fields are don't-care in a bubble, so they load unconditionally.
      rd1_e_q        <= rd1_d;
      rd2_e_q        <= rd2_d;
      imm_e_q        <= imm_d;
      pc_e_q         <= PCD;
      pc_plus4_e_q   <= PCPlus4D;
      rd_e_q         <= rd_d;
      rs1_e_q        <= rs1_d;
      rs2_e_q        <= rs2_d;
    end
  end

  assign ValidE      = valid_e_q;
  assign RegWriteE   = reg_write_e_q;
  assign ALUSrcE     = alu_src_e_q;
  assign MemWriteE   = mem_write_e_q;
  assign ResultSrcE  = result_src_e_q;
  assign BranchE     = branch_e_q;
  assign ALUControlE = alu_ctrl_e_q;
  assign RD1_E       = rd1_e_q;
  assign RD2_E       = rd2_e_q;
  assign Imm_Ext_E   = imm_e_q;
  assign PCE         = pc_e_q;
  assign PCPlus4E    = pc_plus4_e_q;
  assign RD_E        = rd_e_q;
  assign RS1_E       = rs1_e_q;
  assign RS2_E       = rs2_e_q;

endmodule

// File: tb/tb_decode_stage_hz.sv
// Directed bench for decode_stage_hz: default 32-bit/32-register instance plus a
// 64-bit/16-register instance. Bypass expectations follow DECODE_WB_BYPASS_EN.
module tb_decode_stage_hz;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Default instance
  logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
  logic        ValidD, FlushE, RegWriteW;
  logic [4:0]  RDW;
  logic        StallD, ValidE, RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E;
  logic [4:0]  RD_E, RS1_E, RS2_E;

  decode_stage_hz dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .ValidD(ValidD), .FlushE(FlushE), .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW),
    .StallD(StallD), .ValidE(ValidE), .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE),
    .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE), .BranchE(BranchE),
    .ALUControlE(ALUControlE), .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E),
    .PCE(PCE), .PCPlus4E(PCPlus4E), .RD_E(RD_E), .RS1_E(RS1_E), .RS2_E(RS2_E)
  );

  // Wide instance: XLEN=64, ADDR_W=4
  logic [31:0] w_InstrD;
  logic [63:0] w_PCD, w_PCPlus4D, w_ResultW;
  logic        w_ValidD, w_FlushE, w_RegWriteW;
  logic [3:0]  w_RDW;
  logic        w_StallD, w_ValidE, w_RegWriteE, w_ALUSrcE, w_MemWriteE, w_ResultSrcE;
  logic        w_BranchE;
  logic [2:0]  w_ALUControlE;
  logic [63:0] w_RD1_E, w_RD2_E, w_Imm_Ext_E, w_PCE, w_PCPlus4E;
  logic [3:0]  w_RD_E, w_RS1_E, w_RS2_E;

  decode_stage_hz #(.XLEN(64), .ADDR_W(4)) dut64 (
    .clk(clk), .rst(rst), .InstrD(w_InstrD), .PCD(w_PCD), .PCPlus4D(w_PCPlus4D),
    .ValidD(w_ValidD), .FlushE(w_FlushE), .RegWriteW(w_RegWriteW), .RDW(w_RDW),
    .ResultW(w_ResultW), .StallD(w_StallD), .ValidE(w_ValidE), .RegWriteE(w_RegWriteE),
    .ALUSrcE(w_ALUSrcE), .MemWriteE(w_MemWriteE), .ResultSrcE(w_ResultSrcE),
    .BranchE(w_BranchE), .ALUControlE(w_ALUControlE), .RD1_E(w_RD1_E), .RD2_E(w_RD2_E),
    .Imm_Ext_E(w_Imm_Ext_E), .PCE(w_PCE), .PCPlus4E(w_PCPlus4E), .RD_E(w_RD_E),
    .RS1_E(w_RS1_E), .RS2_E(w_RS2_E)
  );

  localparam logic [31:0] InsAddi5  = 32'h0070_0293; // addi x5,x0,7
  localparam logic [31:0] InsLw6    = 32'h0002_A303; // lw x6,0(x5)
  localparam logic [31:0] InsAdd7   = 32'h0013_03B3; // add x7,x6,x1
  localparam logic [31:0] InsSw     = 32'hFE20_AE23; // sw x2,-4(x1)
  localparam logic [31:0] InsAdd433 = 32'h0031_8233; // add x4,x3,x3
  localparam logic [31:0] InsAdd400 = 32'h0000_0233; // add x4,x0,x0
  localparam logic [31:0] InsSub    = 32'h4062_8433; // sub x8,x5,x6
  localparam logic [31:0] InsBeq    = 32'hFE20_8CE3; // beq x1,x2,-8
  localparam logic [31:0] InsOri    = 32'h0F00_E493; // ori x9,x1,0xF0
  localparam logic [31:0] InsAddi15 = 32'hFFF0_0793; // addi x15,x0,-1
  localparam logic [31:0] InsAddi31 = 32'hFFF0_0F93; // addi x31,x0,-1

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    InstrD = '0; PCD = '0; PCPlus4D = '0; ValidD = 1'b0; FlushE = 1'b0;
    RegWriteW = 1'b0; RDW = '0; ResultW = '0;
    w_InstrD = '0; w_PCD = '0; w_PCPlus4D = '0; w_ValidD = 1'b0; w_FlushE = 1'b0;
    w_RegWriteW = 1'b0; w_RDW = '0; w_ResultW = '0;
  endtask

  task automatic test_reset();
    #2;
    n_tests++; if (ValidE !== 1'b0) begin n_fail++;
      $display("FAIL reset_valid: got %b want 0", ValidE); end
    n_tests++; if (StallD !== 1'b0) begin n_fail++;
      $display("FAIL reset_stall: got %b want 0", StallD); end
    n_tests++; if ({RegWriteE, MemWriteE, ALUControlE, PCE} !== 37'd0) begin n_fail++;
      $display("FAIL reset_outs: got %h want 0", {RegWriteE, MemWriteE, ALUControlE, PCE}); end
    rst = 1'b1;
    tick();
    RegWriteW = 1'b1; RDW = 5'd3; ResultW = 32'h1234_5678;
    tick();
    RegWriteW = 1'b0;
    InstrD = InsLw6; ValidD = 1'b1;
    tick();
    InstrD = InsAdd7;
    #1;
    n_tests++; if (StallD !== 1'b1) begin n_fail++;
      $display("FAIL reset_prestall: got %b want 1", StallD); end
    #2 rst = 1'b0;
    #1;
    n_tests++; if (StallD !== 1'b0) begin n_fail++;
      $display("FAIL reset_midstall_stall: got %b want 0", StallD); end
    n_tests++; if ({ValidE, ResultSrcE, RD_E, PCE} !== 39'd0) begin n_fail++;
      $display("FAIL reset_midstall_outs: got %h want 0", {ValidE, ResultSrcE, RD_E, PCE}); end
    rst = 1'b1;
    InstrD = InsAdd433; ValidD = 1'b1;
    tick();
    n_tests++; if (RD1_E !== 32'd0 || RD2_E !== 32'd0) begin n_fail++;
      $display("FAIL reset_rf_cleared: got %h/%h want 0/0", RD1_E, RD2_E); end
    n_tests++; if (ValidE !== 1'b1) begin n_fail++;
      $display("FAIL reset_release_valid: got %b want 1", ValidE); end
  endtask

  task automatic test_addi();
    InstrD = InsAddi5; PCD = 32'h100; PCPlus4D = 32'h104; ValidD = 1'b1;
    tick();
    n_tests++;
    if ({ValidE, RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE}
        !== 9'b111000_000) begin n_fail++;
      $display("FAIL addi_ctrl: got %b want 111000000",
               {ValidE, RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE}); end
    n_tests++; if (Imm_Ext_E !== 32'd7) begin n_fail++;
      $display("FAIL addi_imm: got %h want 7", Imm_Ext_E); end
    n_tests++; if (RD_E !== 5'd5 || RS1_E !== 5'd0) begin n_fail++;
      $display("FAIL addi_regs: got rd=%0d rs1=%0d want 5/0", RD_E, RS1_E); end
    n_tests++; if (PCE !== 32'h100 || PCPlus4E !== 32'h104) begin n_fail++;
      $display("FAIL addi_pc: got %h/%h want 100/104", PCE, PCPlus4E); end
  endtask

  task automatic test_load_use();
    InstrD = InsLw6; ValidD = 1'b1;
    tick();
    n_tests++; if (ResultSrcE !== 1'b1 || RD_E !== 5'd6) begin n_fail++;
      $display("FAIL lu_load_in_ex: got rs=%b rd=%0d want 1/6", ResultSrcE, RD_E); end
    InstrD = InsAdd7;
    #1;
    n_tests++; if (StallD !== 1'b1) begin n_fail++;
      $display("FAIL lu_stall: got %b want 1", StallD); end
    tick();
    n_tests++; if (ValidE !== 1'b0 || RegWriteE !== 1'b0) begin n_fail++;
      $display("FAIL lu_bubble: got v=%b rw=%b want 0/0", ValidE, RegWriteE); end
    n_tests++; if (StallD !== 1'b0) begin n_fail++;
      $display("FAIL lu_stall_release: got %b want 0", StallD); end
    tick();
    n_tests++;
    if ({ValidE, RegWriteE, ALUControlE, RD_E, RS1_E, RS2_E} !== {2'b11, 3'b000, 5'd7, 5'd6, 5'd1})
    begin n_fail++;
      $display("FAIL lu_add_in_ex: got v=%b rw=%b alu=%b rd=%0d rs1=%0d rs2=%0d",
               ValidE, RegWriteE, ALUControlE, RD_E, RS1_E, RS2_E); end
  endtask

  task automatic test_flush();
    InstrD = InsSw; ValidD = 1'b1; FlushE = 1'b1;
    tick();
    n_tests++; if (MemWriteE !== 1'b0 || ValidE !== 1'b0) begin n_fail++;
      $display("FAIL flush_sw: got mw=%b v=%b want 0/0", MemWriteE, ValidE); end
    FlushE = 1'b0;
    tick();
    n_tests++; if ({ValidE, MemWriteE, ALUSrcE, RegWriteE, ALUControlE} !== 7'b1110_000) begin
      n_fail++;
      $display("FAIL sw_ctrl: got %b want 1110000",
               {ValidE, MemWriteE, ALUSrcE, RegWriteE, ALUControlE}); end
    n_tests++; if (Imm_Ext_E !== 32'hFFFF_FFFC) begin n_fail++;
      $display("FAIL sw_imm: got %h want fffffffc", Imm_Ext_E); end
    // Flush coincident with a load-use stall gives one bubble.
    InstrD = InsLw6;
    tick();
    InstrD = InsAdd7; FlushE = 1'b1;
    #1;
    n_tests++; if (StallD !== 1'b1) begin n_fail++;
      $display("FAIL fs_stall: got %b want 1", StallD); end
    tick();
    FlushE = 1'b0;
    n_tests++; if (ValidE !== 1'b0 || StallD !== 1'b0) begin n_fail++;
      $display("FAIL fs_bubble: got v=%b s=%b want 0/0", ValidE, StallD); end
    tick();
    n_tests++; if (ValidE !== 1'b1 || RD_E !== 5'd7) begin n_fail++;
      $display("FAIL fs_after: got v=%b rd=%0d want 1/7", ValidE, RD_E); end
  endtask

  task automatic test_alu_decode();
    ValidD = 1'b1;
    InstrD = InsSub;
    tick();
    n_tests++; if (ALUControlE !== 3'b001 || RegWriteE !== 1'b1 || ALUSrcE !== 1'b0) begin
      n_fail++;
      $display("FAIL sub: got alu=%b rw=%b as=%b want 001/1/0", ALUControlE, RegWriteE, ALUSrcE);
    end
    InstrD = InsBeq;
    tick();
    n_tests++; if (BranchE !== 1'b1 || ALUControlE !== 3'b001 || RegWriteE !== 1'b0) begin
      n_fail++;
      $display("FAIL beq_ctrl: got br=%b alu=%b rw=%b want 1/001/0",
               BranchE, ALUControlE, RegWriteE); end
    n_tests++; if (Imm_Ext_E !== 32'hFFFF_FFF8) begin n_fail++;
      $display("FAIL beq_imm: got %h want fffffff8", Imm_Ext_E); end
    InstrD = InsOri;
    tick();
    n_tests++; if (ALUControlE !== 3'b011 || Imm_Ext_E !== 32'h0000_00F0) begin n_fail++;
      $display("FAIL ori: got alu=%b imm=%h want 011/000000f0", ALUControlE, Imm_Ext_E); end
    InstrD = InsAddi5; ValidD = 1'b0;
    tick();
    n_tests++; if ({ValidE, RegWriteE, ALUSrcE} !== 3'b000 || RD_E !== 5'd5) begin n_fail++;
      $display("FAIL invalid_gated: got v/rw/as=%b rd=%0d want 000/5",
               {ValidE, RegWriteE, ALUSrcE}, RD_E); end
  endtask

  task automatic test_bypass();
    logic [31:0] exp_rd;
`ifdef DECODE_WB_BYPASS_EN
    exp_rd = 32'hDEAD_BEEF;
`else
    exp_rd = 32'h1111_1111;
`endif
    ValidD = 1'b0;
    RegWriteW = 1'b1; RDW = 5'd3; ResultW = 32'h1111_1111;
    tick();
    ResultW = 32'hDEAD_BEEF; InstrD = InsAdd433; ValidD = 1'b1;
    tick();
    RegWriteW = 1'b0;
    n_tests++; if (RD1_E !== exp_rd || RD2_E !== exp_rd) begin n_fail++;
      $display("FAIL bypass_same_cycle: got %h/%h want %h", RD1_E, RD2_E, exp_rd); end
    tick();
    n_tests++; if (RD1_E !== 32'hDEAD_BEEF) begin n_fail++;
      $display("FAIL bypass_stored: got %h want deadbeef", RD1_E); end
    RegWriteW = 1'b1; RDW = 5'd0; ResultW = 32'h5555_5555; InstrD = InsAdd400;
    tick();
    RegWriteW = 1'b0;
    n_tests++; if (RD1_E !== 32'd0 || RD2_E !== 32'd0) begin n_fail++;
      $display("FAIL x0_write_bypass: got %h/%h want 0/0", RD1_E, RD2_E); end
    tick();
    n_tests++; if (RD1_E !== 32'd0) begin n_fail++;
      $display("FAIL x0_write_stored: got %h want 0", RD1_E); end
  endtask

  task automatic test_wide();
    w_InstrD = InsAddi15; w_ValidD = 1'b1; w_PCD = 64'h1_0000_0000; w_PCPlus4D = 64'h1_0000_0004;
    tick();
    n_tests++; if (w_Imm_Ext_E !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++;
      $display("FAIL wide_imm: got %h want ffffffffffffffff", w_Imm_Ext_E); end
    n_tests++; if (w_RD_E !== 4'd15 || w_RegWriteE !== 1'b1 || w_ValidE !== 1'b1) begin
      n_fail++;
      $display("FAIL wide_rd15: got rd=%0d rw=%b v=%b want 15/1/1", w_RD_E, w_RegWriteE, w_ValidE);
    end
    n_tests++; if (w_PCE !== 64'h1_0000_0000) begin n_fail++;
      $display("FAIL wide_pc: got %h want 100000000", w_PCE); end
    w_InstrD = InsAddi31;
    tick();
    n_tests++; if (w_RD_E !== 4'd15) begin n_fail++;
      $display("FAIL wide_rd_alias: got %0d want 15", w_RD_E); end
    w_ValidD = 1'b0;
  endtask

  initial begin
    idle_inputs();
    test_reset();
    idle_inputs();
    test_addi();
    test_load_use();
    idle_inputs();
    test_flush();
    idle_inputs();
    test_alu_decode();
    idle_inputs();
    test_bypass();
    idle_inputs();
    test_wide();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage_hz.md
Name: decode_stage_hz

Overview:
- Parametrised ID stage with an integrated ID/EX pipeline register for the RV32I pipeline.
- Contains the register file, main/ALU control decode, immediate generation and load-use hazard detection.
- Bubble insertion on load-use stall or on an EX flush (branch taken).
- Sits between the fetch-side IF/ID register and the execute cycle; drives `StallD` back to fetch.

Parameters:
- XLEN, 32, datapath width of register contents, PC and immediates (32 or 64).
- ADDR_W, 5, register-address width; register count NREG = 2**ADDR_W (4 gives a 16-register RV32E-style file).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- InstrD  input  32  instruction in decode.
- PCD  input  XLEN  PC of InstrD.
- PCPlus4D  input  XLEN  PC+4 of InstrD.
- ValidD  input  1  InstrD is a real instruction.
- FlushE  input  1  branch taken in EX; the instruction entering EX is discarded.
- RegWriteW  input  1  writeback enable.
- RDW  input  ADDR_W  writeback destination.
- ResultW  input  XLEN  writeback data.
- StallD  output  1  combinational load-use stall request to IF/ID and PC.
- ValidE  output  1  EX slot holds a real instruction.
- RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE  output  1 each  registered control.
- ALUControlE  output  3  registered ALU op.
- RD1_E, RD2_E, Imm_Ext_E  output  XLEN  registered operands and immediate.
- PCE, PCPlus4E  output  XLEN  registered PC values.
- RD_E, RS1_E, RS2_E  output  ADDR_W  registered register addresses.

Behaviour:
- **Register fields:** rs1 = InstrD[15+:ADDR_W], rs2 = InstrD[20+:ADDR_W], rd = InstrD[7+:ADDR_W]; upper field bits are ignored.
- **Register file:**
  - NREG x XLEN; written on posedge when RegWriteW=1 and RDW!=0.
  - Reads are combinational; register 0 always reads 0.
  - Reset clears all entries to 0.
- **Decode by opcode** (all others yield all-zero control):
  - 0000011 lw: RegWrite=1, ALUSrc=1, ResultSrc=1, ImmSrc=I.
  - 0100011 sw: MemWrite=1, ALUSrc=1, ImmSrc=S.
  - 0110011 R-type: RegWrite=1.
  - 0010011 I-ALU: RegWrite=1, ALUSrc=1, ImmSrc=I.
  - 1100011 beq: Branch=1, ImmSrc=B.
- **ALUControl:**
  - 000 add for lw/sw.
  - 001 sub for beq.
  - For R/I-ALU by funct3:
    - 000 gives add, or sub when R-type and InstrD[30]=1.
    - 010 gives slt = 101.
    - 110 gives or = 011.
    - 111 gives and = 010.
    - Other funct3 values give 000.
- **Immediates:** I/S/B formats per RV32I, sign-extended from InstrD[31] to XLEN; B has LSB 0.
- **Hazard detect:** StallD = ValidE & ResultSrcE & (RD_E!=0) & ((RD_E==rs1) | (RD_E==rs2)).
  - rs2 is compared even for I-type; this conservative stall is intended.
- **ID/EX register:** async clear on rst=0; every output resets to 0, including ValidE=0 and StallD=0.
- **Each posedge, by priority:**
  1. FlushE=1: bubble.
  2. StallD=1: bubble; InstrD is held upstream and re-decoded next cycle.
  3. Otherwise: load all decoded values; ValidE=ValidD.
  - If ValidD=0, control bits are still loaded but gated to 0.
- **Bubble:**
  - ValidE, RegWriteE, MemWriteE, BranchE, ResultSrcE, ALUSrcE = 0; ALUControlE = 000.
  - Data/address fields are loaded normally, since they are don't-care.
- **Latency:** 1 cycle from D inputs to E outputs.
- **Simultaneous events:**
  - FlushE with StallD gives a single bubble; StallD deasserts next cycle, since ValidE=0.
  - Reset mid-stall clears StallD immediately (asynchronous path via ValidE=0).

Optional Feature:
- Macro: `DECODE_WB_BYPASS_EN`.
- Defined: write-through read. If RegWriteW=1, RDW!=0 and RDW==rs1 (or rs2), RD1_D (RD2_D) = ResultW in the same cycle.
- Undefined: reads return the stored value. The WB-to-ID same-cycle hazard is then the responsibility of the hazard unit/compiler.

Test Plan:
- **Reset:** assert rst=0 mid-run with StallD=1 → all E outputs 0 and StallD=0 immediately; registers read 0 after release.
- **addi x5,x0,7** (0x00700293), ValidD=1 → next cycle RegWriteE=1, ALUSrcE=1, ALUControlE=000, Imm_Ext_E=7, RD_E=5, ValidE=1.
- **Load-use:** lw x6,0(x5) then add x7,x6,x1 → StallD=1 for one cycle, bubble in EX (ValidE=0, RegWriteE=0); the add enters EX the following cycle with ALUControlE=000.
- **FlushE=1** with sw in decode → MemWriteE=0 and ValidE=0 next cycle; without flush, MemWriteE=1 and Imm_Ext_E equals the S-immediate (0xFFFFFFFC for offset -4).
- **Bypass:** write x3=0xDEADBEEF (RegWriteW=1, RDW=3) while decoding add x4,x3,x3:
  - With `DECODE_WB_BYPASS_EN`: RD1_E=RD2_E=0xDEADBEEF.
  - Without: old value.
  - Writes to x0 ignored: RD1_E=0.
- **ADDR_W=4, XLEN=64:** addi x15,x0,-1 → Imm_Ext_E=0xFFFFFFFFFFFFFFFF; InstrD rd field 31 aliases to RD_E=15.
